// File: rtl/piso_pkg.sv
// Shared types and constants for the parallel-in/serial-out transmitter.
// Both the top level and the bit counter import this package.
package piso_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_t;

endpackage : piso_pkg

// File: rtl/piso_bit_cnt.sv
// Bit position counter for one serialized word.
// tc flags the final bit; the count saturates there and never exceeds WIDTH-1.
module piso_bit_cnt
    import piso_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic tc
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (inc && !tc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign tc = (cnt_q == LAST_CNT);

endmodule : piso_bit_cnt

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter with a valid/ready load port and a bit-rate tick.
// A new word can be accepted on the same cycle the previous word's last bit retires.
module piso_tx
    import piso_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             bit_en,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last,
    output logic             busy
);

    piso_state_t      state_q;
    piso_state_t      state_d;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic             cnt_clear;
    logic             cnt_inc;
    logic             cnt_tc;
    logic             accept;
    logic             retire;

    assign accept = load_valid && load_ready;
    assign retire = (state_q == SHIFT) && bit_en;

    piso_bit_cnt #(
        .WIDTH (WIDTH)
    ) u_bit_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (cnt_clear),
        .inc   (cnt_inc),
        .tc    (cnt_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_clear = accept;
        cnt_inc   = retire;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_en && cnt_tc) begin
                    state_d = accept ? SHIFT : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // The outgoing bit always sits at the end of the register that drives sout.
        if (accept) begin
            shreg_d = load_data;
        end else if (retire) begin
            if (MSB_FIRST) begin
                shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            end else begin
                shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
            end
        end
    end

    always_comb begin
        busy       = (state_q == SHIFT);
        sout_valid = (state_q == SHIFT);
        sout_last  = (state_q == SHIFT) && cnt_tc;
        sout       = 1'b0;
        if (state_q == SHIFT) begin
            sout = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
        end
        load_ready = !rst && ((state_q == IDLE) || (sout_last && bit_en));
    end

endmodule : piso_tx

// File: tb/tb_piso_tx.sv
// Randomized and directed bench for piso_tx (WIDTH=8), checking an MSB-first
// and an LSB-first instance against a bits-remaining model every cycle.
module tb_piso_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_valid;
    logic [7:0] load_data;
    logic       bit_en;

    logic rdy_m, sout_m, val_m, last_m, busy_m;
    logic rdy_l, sout_l, val_l, last_l, busy_l;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: number of bits of the current word still to be shown, and the word.
    int         rem  [2];
    logic [7:0] word [2];

    logic obs_sout, obs_valid, obs_last, obs_ready, obs_busy, obs_sout_l;

    always #5 clk = ~clk;

    piso_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (rdy_m),
        .load_data  (load_data),
        .bit_en     (bit_en),
        .sout       (sout_m),
        .sout_valid (val_m),
        .sout_last  (last_m),
        .busy       (busy_m)
    );

    piso_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (rdy_l),
        .load_data  (load_data),
        .bit_en     (bit_en),
        .sout       (sout_l),
        .sout_valid (val_l),
        .sout_last  (last_l),
        .busy       (busy_l)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare both DUTs to the model, advance the model.
    task automatic step(input logic r, input logic lv, input logic [7:0] d, input logic be);
        logic e_valid, e_sout, e_last, e_ready, acc;
        rst        = r;
        load_valid = lv;
        load_data  = d;
        bit_en     = be;
        #1;
        e_ready = !r && (rem[0] == 0 || (rem[0] == 1 && be));
        for (int i = 0; i < 2; i++) begin
            e_valid = (rem[i] > 0);
            e_last  = (rem[i] == 1);
            e_sout  = 1'b0;
            if (rem[i] > 0) begin
                e_sout = (i == 0) ? word[i][rem[i]-1] : word[i][8-rem[i]];
            end
            if (i == 0) begin
                chk("msb.sout", sout_m, e_sout);
                chk("msb.sout_valid", val_m, e_valid);
                chk("msb.sout_last", last_m, e_last);
                chk("msb.busy", busy_m, e_valid);
                chk("msb.load_ready", rdy_m, e_ready);
            end else begin
                chk("lsb.sout", sout_l, e_sout);
                chk("lsb.sout_valid", val_l, e_valid);
                chk("lsb.sout_last", last_l, e_last);
                chk("lsb.busy", busy_l, e_valid);
                chk("lsb.load_ready", rdy_l, e_ready);
            end
        end
        obs_sout   = sout_m;
        obs_valid  = val_m;
        obs_last   = last_m;
        obs_ready  = rdy_m;
        obs_busy   = busy_m;
        obs_sout_l = sout_l;
        acc = lv && e_ready;
        if (acc) $display("accept word 0x%02h at %0t", d, $time);
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                rem[i]  = 0;
                word[i] = 8'h00;
            end else begin
                if (rem[i] > 0 && be) rem[i] = rem[i] - 1;
                if (acc) begin
                    rem[i]  = 8;
                    word[i] = d;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0]  v8, m8, vl;
        logic [15:0] v16;
        int          vc;
        logic        be;

        rst = 1'b1; load_valid = 1'b0; load_data = 8'h00; bit_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rem[i]  = 0;
            word[i] = 8'h00;
        end
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        step(1'b1, 1'b1, 8'h55, 1'b1);
        chk("rst.busy", obs_busy, 1'b0);
        chk("rst.load_ready", obs_ready, 1'b0);

        // Single word, bit_en constant
        step(1'b0, 1'b1, 8'hA5, 1'b1);
        chk("a.accept_ready", obs_ready, 1'b1);
        v8 = '0; m8 = '0;
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1);
            v8 = {v8[6:0], obs_sout};
            m8 = {m8[6:0], obs_last};
        end
        chk("a.bits", v8, 8'hA5);
        chk("a.last_mask", m8, 8'h01);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("a.done_valid", obs_valid, 1'b0);

        // Back-to-back words with no gap
        step(1'b0, 1'b1, 8'hA5, 1'b1);
        v16 = '0; m8 = '0; vc = 0;
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b1, 8'h3C, 1'b1);
            v16 = {v16[14:0], obs_sout};
            m8  = {m8[6:0], obs_ready};
            vc  = vc + int'(obs_valid);
        end
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1);
            v16 = {v16[14:0], obs_sout};
            vc  = vc + int'(obs_valid);
        end
        chk("b.bits", v16, 16'hA53C);
        chk("b.ready_mask", m8, 8'h01);
        chk("b.valid_count", vc, 16);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("b.done_valid", obs_valid, 1'b0);

        // bit_en every third cycle
        step(1'b0, 1'b1, 8'hF0, 1'b0);
        v8 = '0; vc = 0;
        for (int k = 0; k < 24; k++) begin
            be = (k % 3 == 2);
            step(1'b0, 1'b0, 8'h00, be);
            vc = vc + int'(obs_valid);
            if (be) v8 = {v8[6:0], obs_sout};
        end
        chk("c.bits", v8, 8'hF0);
        chk("c.valid_count", vc, 24);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("c.done_valid", obs_valid, 1'b0);

        // LSB-first order
        step(1'b0, 1'b1, 8'h01, 1'b1);
        vl = '0;
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1);
            vl = {vl[6:0], obs_sout_l};
        end
        chk("d.lsb_bits", vl, 8'h80);
        step(1'b0, 1'b0, 8'h00, 1'b1);

        // load_valid mid-word ignored, accepted at last-bit retire
        step(1'b0, 1'b1, 8'hA5, 1'b1);
        v8 = '0; m8 = '0;
        for (int k = 0; k < 8; k++) begin
            step(1'b0, (k == 3) || (k == 7), 8'hFF, 1'b1);
            v8 = {v8[6:0], obs_sout};
            m8 = {m8[6:0], obs_ready};
        end
        chk("e.bits", v8, 8'hA5);
        chk("e.ready_mask", m8, 8'h01);
        v8 = '0;
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1);
            v8 = {v8[6:0], obs_sout};
        end
        chk("e.second_bits", v8, 8'hFF);
        step(1'b0, 1'b0, 8'h00, 1'b1);

        // Reset mid-word, then a clean word
        step(1'b0, 1'b1, 8'hA5, 1'b1);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b1, 8'h77, 1'b1);
        chk("f.rst_ready", obs_ready, 1'b0);
        step(1'b0, 1'b1, 8'h3C, 1'b1);
        chk("f.post_valid", obs_valid, 1'b0);
        chk("f.post_busy", obs_busy, 1'b0);
        chk("f.post_ready", obs_ready, 1'b1);
        v8 = '0;
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1);
            v8 = {v8[6:0], obs_sout};
        end
        chk("f.bits", v8, 8'h3C);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 59) == 0,
                 1'($urandom_range(0, 1)),
                 8'($urandom),
                 $urandom_range(0, 9) < 6);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_piso_tx

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 Parameter WIDTH, default 8, meaning number of bits per word (legal range 2..32).
REQ-002 Parameter MSB_FIRST, default 1, meaning transmit order (1 = bit WIDTH-1 first, 0 = bit 0 first).
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 load_valid  input  1  load_data is valid for transfer.
REQ-006 load_ready  output  1  block accepts a word this cycle.
REQ-007 load_data  input  WIDTH  parallel word to serialize.
REQ-008 bit_en  input  1  bit-rate tick; the current bit retires on a cycle with bit_en=1.
REQ-009 sout  output  1  serial data bit.
REQ-010 sout_valid  output  1  sout carries a frame bit.
REQ-011 sout_last  output  1  sout carries the final bit of the word.
REQ-012 busy  output  1  a word is in flight.

Function
REQ-013 Two states SHALL exist: IDLE and SHIFT.
REQ-014 A word SHALL be accepted on a rising edge where load_valid=1, load_ready=1 and rst=0.
REQ-015 load_ready SHALL be 1 in IDLE, and 1 in SHIFT only on the cycle where sout_last=1 and bit_en=1; otherwise 0; forced 0 while rst=1.
REQ-016 On accept, the block SHALL enter SHIFT, capture load_data into a shift register, and clear the bit counter to 0.
REQ-017 The first bit SHALL appear on sout, with sout_valid=1, the cycle after accept (latency 1).
REQ-018 Each bit SHALL be held on sout until a cycle with bit_en=1; on the next cycle the next bit SHALL be presented and the counter SHALL increment.
REQ-019 Bit order SHALL be MSB first when MSB_FIRST=1 and LSB first when MSB_FIRST=0.
REQ-020 sout_last SHALL be 1 exactly while the counter equals WIDTH-1 in SHIFT.
REQ-021 When the last bit retires with no accept, the state SHALL return to IDLE and sout, sout_valid, sout_last SHALL be 0 next cycle.
REQ-022 When the last bit retires and an accept occurs the same cycle, the next word's first bit SHALL appear the following cycle with no gap and sout_valid held at 1.
REQ-023 load_valid during SHIFT outside the last-bit retire cycle SHALL be ignored; load_data is not sampled.
REQ-024 busy SHALL equal 1 in SHIFT, 0 in IDLE.
REQ-025 The counter SHALL be $clog2(WIDTH) bits wide and SHALL never exceed WIDTH-1.
REQ-026 bit_en in IDLE SHALL have no effect.

Reset
REQ-027 While rst=1 on a rising edge: state=IDLE, counter=0, shift register=0, sout=0, sout_valid=0, sout_last=0, busy=0.
REQ-028 rst asserted mid-frame SHALL abort the word; no remaining bits are emitted and no accept occurs that cycle.
REQ-029 The first accept after reset SHALL be possible on the first edge with rst=0.

Structure
REQ-030 State enum (IDLE, SHIFT) and default WIDTH constant SHALL live in shared package piso_pkg.
REQ-031 The bit counter with terminal-count flag SHALL be one sub-module, piso_bit_cnt; the rest is flat in piso_tx.

Verification (WIDTH=8)
REQ-032 MSB_FIRST=1, bit_en=1 constant, load 0xA5 -> sout 1,0,1,0,0,1,0,1 on cycles 1..8 after accept, sout_last only on cycle 8, sout_valid 0 on cycle 9.
REQ-033 Back-to-back: 0xA5 then 0x3C held valid -> 16 contiguous valid bits 10100101 00111100, load_ready pulses on cycle 8, no gap.
REQ-034 bit_en every 3rd cycle, load 0xF0 -> each bit held 3 cycles, 24 cycles of sout_valid, order 11110000.
REQ-035 MSB_FIRST=0, load 0x01 -> sout 1,0,0,0,0,0,0,0.
REQ-036 load_valid=1 with 0xFF on bit 3 of 0xA5 -> ignored, 0xA5 completes, 0xFF accepted at last-bit retire.
REQ-037 rst=1 at bit 4 of 0xA5 -> next cycle sout_valid=0, busy=0, load_ready=1 after rst drops; next load 0x3C transmits correctly.
